mult_issue_queue: RTL and testbench

Issue-side initiator for the multiplier functional unit. It buffers ready multiply operations handed over by the reservation station and drives `FU_IN_PACKET` into `mult_fu` one operation at a time. It tracks the FU as busy from issue until the CDB acknowledges that FU's result, then issues the next queued operation. It sits between the RS multiply port and `mult_fu`, and observes the `ack` bit that `cdb` returns for the FU.

---
 rtl/mult_issue_queue_pkg.sv | 38 +++
 rtl/mult_issue_queue_fifo.sv | 51 +++++
 rtl/mult_issue_queue.sv | 70 +++++++
 tb/tb_mult_issue_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_issue_queue_pkg.sv
// Shared types for the multiply issue queue: queue entries, the FU drive
// packet and the CDB acknowledge packet.
package mult_issue_queue_pkg;

   localparam int XLEN          = 32;
   localparam int ROB_TAG_W     = 5;
   localparam int NUM_FU        = 4;
   localparam int MULT_IQ_DEPTH = 4;

   typedef logic [ROB_TAG_W-1:0] ROB_TAG;

   typedef struct packed {
      logic [XLEN-1:0] rs1_value;
      logic [XLEN-1:0] rs2_value;
      ROB_TAG          tag;
   } MULT_ISSUE_ENTRY;

   typedef struct packed {
      logic            issue_valid;
      logic [XLEN-1:0] rs1_value;
      logic [XLEN-1:0] rs2_value;
      ROB_TAG          tag;
   } FU_IN_PACKET;

   typedef struct packed {
      logic [NUM_FU-1:0] ack;
   } CDB_EX_PACKET;

   function automatic FU_IN_PACKET issue_packet(input MULT_ISSUE_ENTRY e);
      FU_IN_PACKET p;
      p.issue_valid = 1'b1;
      p.rs1_value   = e.rs1_value;
      p.rs2_value   = e.rs2_value;
      p.tag         = e.tag;
      return p;
   endfunction

endpackage

// File: rtl/mult_issue_queue_fifo.sv
// Generic synchronous circular-buffer FIFO exposing the head entry and the
// occupancy count; the caller must not push when full or pop when empty.
module mult_issue_queue_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  T                         push_data,
   output T                         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T               mem [DEPTH];
   logic [AW-1:0]  head_reg;
   logic [AW-1:0]  tail_reg;
   logic [CW-1:0]  count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + AW'(1);
         if (pop)  head_reg <= head_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; stale slots are never read while count excludes them.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
         if (push && !reset && tail_reg == AW'(gi))
            mem[gi] <= push_data;
      end
   end

   assign head_data = mem[head_reg];
   assign count     = count_reg;

endmodule

// File: rtl/mult_issue_queue.sv
// Buffers ready multiply operations and issues them one at a time into the
// multiplier, holding the FU busy until the CDB acknowledges its result.
module mult_issue_queue
   import mult_issue_queue_pkg::*;
#(
   parameter int DEPTH  = MULT_IQ_DEPTH,
   parameter int FU_IDX = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     enq_valid,
   input  MULT_ISSUE_ENTRY          enq_entry,
   output logic                     enq_ready,
   input  CDB_EX_PACKET             cdb_ex_packet,
   output FU_IN_PACKET              fu_in_packet,
   output logic                     fu_busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic            flush;
   logic            ack_i;
   logic            push;
   logic            issue;
   MULT_ISSUE_ENTRY head_entry;
   FU_IN_PACKET     fu_in_packet_reg;
   logic            fu_busy_reg;
   logic            unused_ack;

   assign flush      = reset | clear;
   assign ack_i      = cdb_ex_packet.ack[FU_IDX];
   assign unused_ack = ^cdb_ex_packet.ack;

   // Ready looks only at the registered count, so a same-cycle issue never frees a slot early.
   assign enq_ready = (count < CW'(DEPTH));
   assign push      = enq_valid && enq_ready;
   assign issue     = (count != '0) && (!fu_busy_reg || ack_i);

   mult_issue_queue_fifo #(
      .DEPTH (DEPTH),
      .T     (MULT_ISSUE_ENTRY)
   ) u_fifo (
      .clock     (clock),
      .reset     (flush),
      .push      (push),
      .pop       (issue),
      .push_data (enq_entry),
      .head_data (head_entry),
      .count     (count)
   );

   always_ff @(posedge clock) begin
      if (flush) begin
         fu_in_packet_reg <= '0;
         fu_busy_reg      <= 1'b0;
      end else if (issue) begin
         fu_in_packet_reg <= issue_packet(head_entry);
         fu_busy_reg      <= 1'b1;
      end else begin
         fu_in_packet_reg.issue_valid <= 1'b0;
         if (ack_i) fu_busy_reg <= 1'b0;
      end
   end

   assign fu_in_packet = fu_in_packet_reg;
   assign fu_busy      = fu_busy_reg;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue: reset, single op, back-to-back,
// full boundary, clear, spurious ack and a modelled wrap-around run.
module tb_mult_issue_queue;
   import mult_issue_queue_pkg::*;

   localparam int DEPTH = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            clear;
   logic            enq_valid;
   MULT_ISSUE_ENTRY enq_entry;
   logic            enq_ready;
   CDB_EX_PACKET    cdb_ex_packet;
   FU_IN_PACKET     fu_in_packet;
   logic            fu_busy;
   logic [2:0]      count;

   int passes = 0;
   int total  = 0;

   always #5 clock = ~clock;

   mult_issue_queue #(.DEPTH(DEPTH), .FU_IDX(1)) dut (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear),
      .enq_valid     (enq_valid),
      .enq_entry     (enq_entry),
      .enq_ready     (enq_ready),
      .cdb_ex_packet (cdb_ex_packet),
      .fu_in_packet  (fu_in_packet),
      .fu_busy       (fu_busy),
      .count         (count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      enq_valid           = 1'b1;
      enq_entry.rs1_value = a;
      enq_entry.rs2_value = b;
      enq_entry.tag       = t;
   endtask

   task automatic check_issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] t);
      check({tag, "_valid"}, 64'(fu_in_packet.issue_valid), 64'd1);
      check({tag, "_rs1"},   64'(fu_in_packet.rs1_value),   64'(a));
      check({tag, "_rs2"},   64'(fu_in_packet.rs2_value),   64'(b));
      check({tag, "_tag"},   64'(fu_in_packet.tag),         64'(t));
   endtask

   MULT_ISSUE_ENTRY model_q[$];
   MULT_ISSUE_ENTRY exp_e;
   logic            busy_m;
   logic            acc_m;
   logic            iss_m;
   int              offered;
   int              issued;
   int              cycles;

   initial begin
      reset = 1'b1; clear = 1'b0; enq_valid = 1'b0; enq_entry = '0; cdb_ex_packet = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_enq_ready", 64'(enq_ready), 64'd1);
      check("rst_count",     64'(count),     64'd0);
      check("rst_busy",      64'(fu_busy),   64'd0);
      check("rst_packet",    64'(fu_in_packet == '0), 64'd1);

      // Single operation: accepted at edge N, issued at edge N+1.
      offer(2, 3, 2);
      tick();
      enq_valid = 1'b0;
      check("t1_count_after_enq", 64'(count), 64'd1);
      check("t1_no_bypass", 64'(fu_in_packet.issue_valid), 64'd0);
      tick();
      check_issue("t1_issue", 2, 3, 2);
      check("t1_busy", 64'(fu_busy), 64'd1);
      check("t1_count_after_issue", 64'(count), 64'd0);
      tick();
      check("t1_pulse_end", 64'(fu_in_packet.issue_valid), 64'd0);
      check("t1_hold_tag", 64'(fu_in_packet.tag), 64'd2);
      cdb_ex_packet.ack = 4'b0010;
      tick();
      cdb_ex_packet = '0;
      check("t1_busy_drop", 64'(fu_busy), 64'd0);

      // Back-to-back issue paced by acks.
      offer(5, 50, 3);
      tick();
      offer(7, 8, 4);
      tick();
      check_issue("t2_op3", 5, 50, 3);
      offer(32'hFFFF_FFFF, 2, 5);
      tick();
      enq_valid = 1'b0;
      check("t2_wait", 64'(fu_in_packet.issue_valid), 64'd0);
      check("t2_count2", 64'(count), 64'd2);
      cdb_ex_packet.ack = 4'b0010;
      tick();
      cdb_ex_packet = '0;
      check_issue("t2_op4", 7, 8, 4);
      check("t2_count1", 64'(count), 64'd1);
      tick();
      check("t2_gap", 64'(fu_in_packet.issue_valid), 64'd0);
      cdb_ex_packet.ack = 4'b0010;
      tick();
      check_issue("t2_op5", 32'hFFFF_FFFF, 2, 5);
      tick();
      cdb_ex_packet = '0;
      check("t2_idle", 64'(fu_busy), 64'd0);

      // Full boundary with the FU held busy.
      for (int i = 0; i < 5; i++) begin
         offer(32'(i + 10), 32'(i + 1), 5'(i + 8));
         tick();
      end
      offer(99, 99, 31);
      check("t3_full_ready", 64'(enq_ready), 64'd0);
      check("t3_full_count", 64'(count), 64'd4);
      tick();
      check("t3_sixth_dropped", 64'(count), 64'd4);
      enq_valid = 1'b0;
      cdb_ex_packet.ack = 4'b0010;
      tick();
      cdb_ex_packet = '0;
      check_issue("t3_after_ack", 11, 2, 9);
      check("t3_count3", 64'(count), 64'd3);
      check("t3_ready_back", 64'(enq_ready), 64'd1);

      // Clear while busy with queued entries and a live offer.
      offer(77, 77, 30);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      enq_valid = 1'b0;
      check("t5_count", 64'(count), 64'd0);
      check("t5_busy", 64'(fu_busy), 64'd0);
      check("t5_valid", 64'(fu_in_packet.issue_valid), 64'd0);
      check("t5_packet", 64'(fu_in_packet == '0), 64'd1);
      tick();
      check("t5_not_stored", 64'(count), 64'd0);

      // Spurious acks.
      cdb_ex_packet.ack = 4'b0010;
      tick();
      cdb_ex_packet = '0;
      check("t6_idle_busy", 64'(fu_busy), 64'd0);
      check("t6_idle_valid", 64'(fu_in_packet.issue_valid), 64'd0);
      offer(4, 4, 1);
      tick();
      enq_valid = 1'b0;
      tick();
      check("t6_issued", 64'(fu_busy), 64'd1);
      cdb_ex_packet.ack = 4'b0001;
      tick();
      check("t6_other_fu_ack", 64'(fu_busy), 64'd1);
      cdb_ex_packet.ack = 4'b0010;
      tick();
      cdb_ex_packet = '0;
      check("t6_own_ack", 64'(fu_busy), 64'd0);

      // Wrap-around: random offers and acks against a reference model.
      busy_m = 1'b0; offered = 0; issued = 0; cycles = 0;
      while (issued < 3 * DEPTH && cycles < 500) begin
         enq_valid = (offered < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
         enq_entry.rs1_value = $urandom;
         enq_entry.rs2_value = $urandom;
         enq_entry.tag       = 5'($urandom_range(0, 31));
         cdb_ex_packet.ack   = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
         #1;
         acc_m = enq_valid && (model_q.size() < DEPTH);
         iss_m = (model_q.size() > 0) && (!busy_m || cdb_ex_packet.ack[1]);
         if (enq_ready !== (model_q.size() < DEPTH))
            check("t4_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
         if (iss_m) exp_e = model_q.pop_front();
         if (acc_m) begin
            model_q.push_back(enq_entry);
            offered++;
         end
         if (iss_m) busy_m = 1'b1;
         else if (cdb_ex_packet.ack[1]) busy_m = 1'b0;
         tick();
         cycles++;
         check("t4_valid", 64'(fu_in_packet.issue_valid), 64'(iss_m));
         if (iss_m) begin
            check("t4_rs1", 64'(fu_in_packet.rs1_value), 64'(exp_e.rs1_value));
            check("t4_rs2", 64'(fu_in_packet.rs2_value), 64'(exp_e.rs2_value));
            check("t4_tag", 64'(fu_in_packet.tag), 64'(exp_e.tag));
            issued++;
         end
      end
      enq_valid = 1'b0;
      cdb_ex_packet = '0;
      check("t4_all_issued", 64'(issued), 64'(3 * DEPTH));
      check("t4_count", 64'(count), 64'(model_q.size()));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
